// File: rtl/serial_byte_loader_pkg.sv
// Shared definitions for the serial byte loader: FSM state encoding and default word width.
package serial_byte_loader_pkg;

   typedef enum logic [1:0] {
      SHIFT = 2'd0,
      EVAL  = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int unsigned W_DEFAULT = 8;

endpackage

// File: rtl/serial_byte_loader_shift_in_reg.sv
// W-bit MSB-first shift register with a bit counter that flags the final bit of a word.
module shift_in_reg
   import serial_byte_loader_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   input  logic         SI,
   output logic [W-1:0] Q,
   output logic         LAST
);

   localparam int unsigned CW = $clog2(W);

   logic [W-1:0]  shreg;
   logic [CW-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (EN) begin
         shreg <= {shreg[W-2:0], SI};
         // Counter only returns to zero on the final bit, so it never passes W-1.
         if (LAST) cnt <= '0;
         else      cnt <= cnt + 1'b1;
      end
   end

   assign Q    = shreg;
   assign LAST = (cnt == CW'(W - 1));

endmodule

// File: rtl/serial_byte_loader.sv
// Deserialises an MSB-first bit stream into I, captures the decode result O, and offers it on VALID/ACK.
module serial_byte_loader
   import serial_byte_loader_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         SI,
   input  logic         SV,
   input  logic         O,
   output logic [W-1:0] I,
   output logic         RES,
   output logic         VALID,
   input  logic         ACK,
   output logic         OVR
);

   state_t       state, state_nx;
   logic         en;
   logic         last;
   logic [W-1:0] q;

   // Strobes outside SHIFT never reach the shift register; they only raise OVR.
   assign en = SV && (state == SHIFT);

   shift_in_reg #(.W(W)) u_shift (
      .CLK  (CLK),
      .RST  (RST),
      .EN   (en),
      .SI   (SI),
      .Q    (q),
      .LAST (last)
   );

   always_ff @(posedge CLK) begin
      if (RST) state <= SHIFT;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         SHIFT:   if (en && last) state_nx = EVAL;
         EVAL:    state_nx = HOLD;
         HOLD:    if (ACK) state_nx = SHIFT;
         default: state_nx = SHIFT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         I     <= '0;
         RES   <= 1'b0;
         VALID <= 1'b0;
         OVR   <= 1'b0;
      end else begin
         if (en && last)               I     <= {q[W-2:0], SI};
         if (state == EVAL) begin
            RES   <= O;
            VALID <= 1'b1;
         end
         if ((state == HOLD) && ACK)   VALID <= 1'b0;
         if (SV && (state != SHIFT))   OVR   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_serial_byte_loader.sv
// Self-checking bench for serial_byte_loader: directed scenarios plus random traffic against a word-level model.
module tb_serial_byte_loader;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       SI  = 1'b0;
   logic       SV  = 1'b0;
   logic       ACK = 1'b0;
   logic       O;
   logic [7:0] I;
   logic       RES, VALID, OVR;

   logic       o_flip = 1'b0;

   // Stand-in decode stage: odd parity of the word, optionally inverted to probe RES capture timing.
   assign O = (^I) ^ o_flip;

   serial_byte_loader #(.W(8)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .SI    (SI),
      .SV    (SV),
      .O     (O),
      .I     (I),
      .RES   (RES),
      .VALID (VALID),
      .ACK   (ACK),
      .OVR   (OVR)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int vpulses = 0;

   // Reference model: phase 0 collecting bits, 1 word just loaded, 2 result offered.
   logic [7:0] m_I = '0, m_acc = '0;
   int         m_n = 0, m_ph = 0;
   logic       m_res = 1'b0, m_valid = 1'b0, m_ovr = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic rst, input logic sv, input logic si, input logic ack);
      logic o_v;
      RST = rst; SV = sv; SI = si; ACK = ack;
      o_v = (^m_I) ^ o_flip;
      @(posedge CLK);
      if (rst) begin
         m_I = '0; m_acc = '0; m_n = 0; m_ph = 0;
         m_res = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
      end else if (m_ph == 0) begin
         if (sv) begin
            m_acc = 8'((m_acc * 2) + si);
            m_n++;
            if (m_n == 8) begin
               m_I = m_acc; m_n = 0; m_ph = 1;
            end
         end
      end else if (m_ph == 1) begin
         m_res = o_v; m_valid = 1'b1; m_ph = 2;
         if (sv) m_ovr = 1'b1;
      end else begin
         if (sv) m_ovr = 1'b1;
         if (ack) begin
            m_valid = 1'b0; m_ph = 0;
         end
      end
      #1;
      check("I", 32'(I), 32'(m_I));
      check("RES", 32'(RES), 32'(m_res));
      check("VALID", 32'(VALID), 32'(m_valid));
      check("OVR", 32'(OVR), 32'(m_ovr));
      if (VALID) vpulses++;
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap, input logic ack);
      for (int i = 7; i >= 0; i--) begin
         int gap;
         gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
         repeat (gap) tick(1'b0, 1'b0, 1'b0, ack);
         tick(1'b0, 1'b1, b[i], ack);
      end
   endtask

   initial begin
      // Reset state
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      check("rst_I", 32'(I), 32'h0);
      check("rst_VALID", 32'(VALID), 32'h0);
      check("rst_OVR", 32'(OVR), 32'h0);

      // Basic word: I loads on the last-bit edge, VALID one edge later
      send_byte(8'h32, 0, 1'b0);
      check("basic_I", 32'(I), 32'd50);
      check("basic_VALID_early", 32'(VALID), 32'h0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("basic_VALID", 32'(VALID), 32'h1);
      check("basic_RES", 32'(RES), 32'(^8'd50));
      tick(1'b0, 1'b0, 1'b0, 1'b1);

      // Sparse strobes
      send_byte(8'h32, 3, 1'b0);
      check("sparse_I", 32'(I), 32'd50);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("sparse_VALID", 32'(VALID), 32'h1);

      // Overrun in HOLD, plus a late O change that must not reach RES
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      check("ovr_OVR", 32'(OVR), 32'h1);
      check("ovr_I", 32'(I), 32'd50);
      o_flip = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("ovr_RES", 32'(RES), 32'(^8'd50));
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      send_byte(8'hFF, 1, 1'b0);
      check("ovr_FF", 32'(I), 32'hFF);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      o_flip = 1'b0;

      // Mid-word reset
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'($urandom_range(1, 0)), 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("mrst_I", 32'(I), 32'h0);
      check("mrst_OVR", 32'(OVR), 32'h0);
      send_byte(8'hA5, 0, 1'b0);
      check("mrst_A5", 32'(I), 32'hA5);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back with ACK tied high
      vpulses = 0;
      send_byte(8'h00, 0, 1'b1);
      check("b2b_I0", 32'(I), 32'h00);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      send_byte(8'hFF, 0, 1'b1);
      check("b2b_I1", 32'(I), 32'hFF);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      check("b2b_pulses", 32'(vpulses), 32'd2);
      check("b2b_OVR", 32'(OVR), 32'h0);

      // SV and ACK together in HOLD
      send_byte(8'h5A, 0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      check("svack_VALID", 32'(VALID), 32'h0);
      check("svack_OVR", 32'(OVR), 32'h1);
      send_byte(8'h3C, 0, 1'b0);
      check("svack_next", 32'(I), 32'h3C);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("svack_VALID2", 32'(VALID), 32'h1);

      // Random traffic
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 600; n++) begin
         o_flip = 1'($urandom_range(1, 0));
         tick(($urandom_range(99, 0) == 0), ($urandom_range(2, 0) != 0),
              1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
